ber_sweep_ctrl: RTL and testbench
=================================

// Module: ber_sweep_ctrl
// PURPOSE
//  Sequences an SNR sweep for BER testing. Steps the AWGN noise_magnitude
//    from a start value by a fixed increment over N points.
//  Per point: gates awgn_generator enable, waits a settle window, then counts
//    symbols and bit errors from the demod/compare path.
//  Hands each point's result out on a valid/ready port.
//  Sits between the host/UART config regs and the I/Q awgn_generator pair.
// PARAMETERS
//  SETTLE_CYCLES  4   cycles awgn_en is high before counting (>= AWGN latency 3 + 1)
//  SYM_CNT_W      20  width of per-point symbol target/counter
//  ERR_CNT_W      24  width of per-point bit-error accumulator (saturating)
// PORTS
//  clk             in   1              clock
//  rst_n           in   1              async active-low reset
//  start           in   1              pulse: latch cfg_*, begin sweep (IDLE only)
//  abort           in   1              pulse: terminate sweep, return to IDLE
//  cfg_mag_start   in   NOISE_MAG_WIDTH  first noise magnitude
//  cfg_mag_step    in   NOISE_MAG_WIDTH  magnitude increment per point
//  cfg_num_pts     in   8              number of sweep points (0 = none)
//  cfg_symbols     in   SYM_CNT_W      symbols measured per point
//  sym_valid       in   1              one compared symbol this cycle
//  sym_bit_err     in   3              bit errors in that symbol (0..4, 16-QAM)
//  noise_magnitude out  NOISE_MAG_WIDTH  to both awgn_generator instances
//  awgn_en         out  1              sample enable to awgn_generator
//  busy            out  1              high in any state except IDLE
//  res_valid       out  1              point result available
//  res_ready       in   1              consumer accepts result
//  res_mag         out  NOISE_MAG_WIDTH  magnitude of reported point
//  res_symbols     out  SYM_CNT_W      symbols counted for point
//  res_errors      out  ERR_CNT_W      bit errors for point
//  done            out  1              1-cycle pulse: sweep completed normally
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters and latched cfg cleared.
//  States:
//   IDLE
//   SETTLE  awgn_en=1, sym_valid ignored
//   MEASURE awgn_en=1, counting
//   REPORT  awgn_en=0, res_valid=1
//   FINISH  one cycle, done=1
//  All outputs are registered.
//  IDLE: start=1 latches cfg_*, sets mag=cfg_mag_start and pt_idx=0.
//   Next state is FINISH if cfg_num_pts==0, else SETTLE.
//   Outputs update on the cycle after start.
//  SETTLE: counts exactly SETTLE_CYCLES cycles, then MEASURE.
//   Symbol and error counters are cleared on entry.
//  MEASURE: each sym_valid adds 1 to sym_cnt and adds sym_bit_err to err_cnt.
//   err_cnt saturates at all-ones and never wraps.
//   The edge that makes sym_cnt==cfg_symbols goes to REPORT; that symbol is
//   included. cfg_symbols==0 goes to REPORT on the first MEASURE cycle with
//   zero counts.
//  REPORT: res_* hold stable while res_valid=1 && !res_ready.
//   On handshake pt_idx++. If pt_idx+1==cfg_num_pts go to FINISH. Otherwise
//   mag=min(mag+step, 2^NOISE_MAG_WIDTH-1) (saturating) and go to SETTLE.
//  FINISH: done=1 for one cycle, then IDLE. busy stays high through FINISH.
//  noise_magnitude: changes only on a REPORT handshake or on start.
//   Stable through SETTLE, MEASURE and REPORT. 0 in IDLE.
//  abort (any state): next cycle IDLE, outputs 0.
//   An in-flight result is dropped and done is not pulsed.
//   abort has priority over start and over a simultaneous REPORT handshake.
//  start while busy: ignored; cfg_* changes while busy: ignored (latched copy).
//  Reset mid-sweep: asynchronous return to reset values; no done pulse.
// STRUCTURE
//  gdsp_pkg gains:
//   typedef enum logic [2:0] {SW_IDLE, SW_SETTLE, SW_MEASURE, SW_REPORT, SW_FINISH} sweep_state_e;
//   localparam BER_SWEEP_SETTLE = 4
//   localparam BER_SYM_CNT_W = 20
//   localparam BER_ERR_CNT_W = 24
//  NOISE_MAG_WIDTH already lives in gdsp_pkg.
//  Single module, no sub-modules. The saturating accumulator is inline
//  (one adder plus an overflow compare).
// TESTING
//  Nominal: start=8, step=8, pts=3, symbols=10, sym_valid every cycle, err=1
//   -> three results: mag 8/16/24, symbols=10, errors=10; done once after the 3rd handshake.
//  Timing: start at cycle 0 -> busy and awgn_en=1 at cycle 1.
//   First counted sym_valid at cycle 1+SETTLE_CYCLES; awgn_en=0 in REPORT.
//  Mag saturation: start=250, step=8, pts=3 -> res_mag 250, 255, 255.
//  Backpressure: res_ready low 20 cycles in REPORT -> res_* stable,
//   awgn_en=0, no new points; handshake resumes at next SETTLE.
//  Abort in MEASURE after 5 symbols -> next cycle IDLE, res_valid=0,
//   noise_magnitude=0, done never pulses. Abort+start same cycle in IDLE -> stays IDLE.
//  Edge cfg: pts=0 -> done 2 cycles after start with no result.
//   symbols=0 -> result with 0/0. ERR_CNT_W=4 with err=4 x 10 -> res_errors=15.

Source files
------------

// File: rtl/gdsp_pkg.sv
// Shared DSP package: noise width, BER sweep states and defaults.
// Imported by the AWGN sweep and test-control blocks.
package gdsp_pkg;

  localparam int NOISE_MAG_WIDTH = 8;

  typedef enum logic [2:0] {
    SW_IDLE,
    SW_SETTLE,
    SW_MEASURE,
    SW_REPORT,
    SW_FINISH
  } sweep_state_e;

  localparam int BER_SWEEP_SETTLE = 4;
  localparam int BER_SYM_CNT_W    = 20;
  localparam int BER_ERR_CNT_W    = 24;

endpackage

// File: rtl/ber_sweep_ctrl.sv
// BER sweep sequencer: steps AWGN magnitude over N points,
// settles, counts symbols/bit errors, reports via valid/ready.
module ber_sweep_ctrl
  import gdsp_pkg::*;
#(
  parameter int SETTLE_CYCLES = BER_SWEEP_SETTLE,
  parameter int SYM_CNT_W     = BER_SYM_CNT_W,
  parameter int ERR_CNT_W     = BER_ERR_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NOISE_MAG_WIDTH-1:0] cfg_mag_start,
  input  logic [NOISE_MAG_WIDTH-1:0] cfg_mag_step,
  input  logic [7:0]                 cfg_num_pts,
  input  logic [SYM_CNT_W-1:0]       cfg_symbols,
  input  logic                       sym_valid,
  input  logic [2:0]                 sym_bit_err,
  output logic [NOISE_MAG_WIDTH-1:0] noise_magnitude,
  output logic                       awgn_en,
  output logic                       busy,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [NOISE_MAG_WIDTH-1:0] res_mag,
  output logic [SYM_CNT_W-1:0]       res_symbols,
  output logic [ERR_CNT_W-1:0]       res_errors,
  output logic                       done
);

  localparam int MW  = NOISE_MAG_WIDTH;
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);

  sweep_state_e         state;
  logic [MW-1:0]        st_step;
  logic [7:0]           st_pts;
  logic [SYM_CNT_W-1:0] st_syms;
  logic [7:0]           pt_idx;
  logic [SCW-1:0]       set_cnt;
  logic [SYM_CNT_W-1:0] sym_cnt;
  logic [ERR_CNT_W-1:0] err_cnt;

  logic [SYM_CNT_W-1:0] sym_nxt;
  logic [ERR_CNT_W:0]   err_sum;
  logic [ERR_CNT_W-1:0] err_nxt;
  logic [MW:0]          mag_sum;
  logic [MW-1:0]        mag_nxt;
  logic                 pt_last;
  logic                 settle_end;

  // Next-count helpers: saturating error add and saturating magnitude step.
  always_comb begin
    sym_nxt    = sym_cnt + SYM_CNT_W'(1);
    err_sum    = {1'b0, err_cnt}
               + {{(ERR_CNT_W - 2){1'b0}}, sym_bit_err};
    err_nxt    = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    mag_sum    = {1'b0, noise_magnitude} + {1'b0, st_step};
    mag_nxt    = mag_sum[MW] ? '1 : mag_sum[MW-1:0];
    pt_last    = (pt_idx + 8'd1) == st_pts;
    settle_end = set_cnt == SCW'(SETTLE_CYCLES - 1);
  end

  // Sweep FSM with all outputs registered; abort overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= SW_IDLE;
      st_step         <= '0;
      st_pts          <= '0;
      st_syms         <= '0;
      pt_idx          <= '0;
      set_cnt         <= '0;
      sym_cnt         <= '0;
      err_cnt         <= '0;
      noise_magnitude <= '0;
      awgn_en         <= 1'b0;
      busy            <= 1'b0;
      res_valid       <= 1'b0;
      res_mag         <= '0;
      res_symbols     <= '0;
      res_errors      <= '0;
      done            <= 1'b0;
    end else if (abort) begin
      state           <= SW_IDLE;
      pt_idx          <= '0;
      set_cnt         <= '0;
      sym_cnt         <= '0;
      err_cnt         <= '0;
      noise_magnitude <= '0;
      awgn_en         <= 1'b0;
      busy            <= 1'b0;
      res_valid       <= 1'b0;
      res_mag         <= '0;
      res_symbols     <= '0;
      res_errors      <= '0;
      done            <= 1'b0;
    end else begin
      unique case (state)
        SW_IDLE: begin
          if (start) begin
            st_step         <= cfg_mag_step;
            st_pts          <= cfg_num_pts;
            st_syms         <= cfg_symbols;
            pt_idx          <= '0;
            noise_magnitude <= cfg_mag_start;
            busy            <= 1'b1;
            set_cnt         <= '0;
            sym_cnt         <= '0;
            err_cnt         <= '0;
            if (cfg_num_pts == 8'd0) begin
              state <= SW_FINISH;
              done  <= 1'b1;
            end else begin
              state   <= SW_SETTLE;
              awgn_en <= 1'b1;
            end
          end
        end
        SW_SETTLE: begin
          if (settle_end) begin
            state <= SW_MEASURE;
          end else begin
            set_cnt <= set_cnt + SCW'(1);
          end
        end
        SW_MEASURE: begin
          if (st_syms == '0) begin
            state       <= SW_REPORT;
            awgn_en     <= 1'b0;
            res_valid   <= 1'b1;
            res_mag     <= noise_magnitude;
            res_symbols <= '0;
            res_errors  <= '0;
          end else if (sym_valid) begin
            sym_cnt <= sym_nxt;
            err_cnt <= err_nxt;
            if (sym_nxt == st_syms) begin
              state       <= SW_REPORT;
              awgn_en     <= 1'b0;
              res_valid   <= 1'b1;
              res_mag     <= noise_magnitude;
              res_symbols <= sym_nxt;
              res_errors  <= err_nxt;
            end
          end
        end
        SW_REPORT: begin
          if (res_ready) begin
            pt_idx      <= pt_idx + 8'd1;
            res_valid   <= 1'b0;
            res_mag     <= '0;
            res_symbols <= '0;
            res_errors  <= '0;
            if (pt_last) begin
              state <= SW_FINISH;
              done  <= 1'b1;
            end else begin
              state           <= SW_SETTLE;
              noise_magnitude <= mag_nxt;
              awgn_en         <= 1'b1;
              set_cnt         <= '0;
              sym_cnt         <= '0;
              err_cnt         <= '0;
            end
          end
        end
        SW_FINISH: begin
          state           <= SW_IDLE;
          done            <= 1'b0;
          busy            <= 1'b0;
          noise_magnitude <= '0;
        end
        default: state <= SW_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// Bench for ber_sweep_ctrl: per-cycle model compare plus
// hand-computed checks of the sweep results.
module tb_ber_sweep_ctrl;
  import gdsp_pkg::*;

  localparam int MW     = NOISE_MAG_WIDTH;
  localparam int MAGMAX = (1 << MW) - 1;
  localparam int ST     = BER_SWEEP_SETTLE;
  localparam int SW     = BER_SYM_CNT_W;
  localparam int EW     = BER_ERR_CNT_W;
  localparam int EMAX   = (1 << EW) - 1;
  localparam int EMAX4  = 15;

  logic          clk, rst_n;
  logic          start, abort;
  logic [MW-1:0] cfg_mag_start, cfg_mag_step;
  logic [7:0]    cfg_num_pts;
  logic [SW-1:0] cfg_symbols;
  logic          sym_valid;
  logic [2:0]    sym_bit_err;
  logic          res_ready;

  logic [MW-1:0] noise_magnitude, res_mag;
  logic          awgn_en, busy, res_valid, done;
  logic [SW-1:0] res_symbols;
  logic [EW-1:0] res_errors;

  logic [MW-1:0] s_noise, s_res_mag;
  logic          s_awgn, s_busy, s_res_valid, s_done;
  logic [SW-1:0] s_res_symbols;
  logic [3:0]    s_res_errors;

  ber_sweep_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_mag_start(cfg_mag_start), .cfg_mag_step(cfg_mag_step),
    .cfg_num_pts(cfg_num_pts), .cfg_symbols(cfg_symbols),
    .sym_valid(sym_valid), .sym_bit_err(sym_bit_err),
    .noise_magnitude(noise_magnitude), .awgn_en(awgn_en),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_mag(res_mag), .res_symbols(res_symbols),
    .res_errors(res_errors), .done(done)
  );

  ber_sweep_ctrl #(.ERR_CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_mag_start(cfg_mag_start), .cfg_mag_step(cfg_mag_step),
    .cfg_num_pts(cfg_num_pts), .cfg_symbols(cfg_symbols),
    .sym_valid(sym_valid), .sym_bit_err(sym_bit_err),
    .noise_magnitude(s_noise), .awgn_en(s_awgn),
    .busy(s_busy), .res_valid(s_res_valid), .res_ready(res_ready),
    .res_mag(s_res_mag), .res_symbols(s_res_symbols),
    .res_errors(s_res_errors), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int dn_cnt = 0;
  int q_mag[$], q_sym[$], q_err[$], q_err4[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 settle, 2 measure, 3 report, 4 finish.
  int ph, m_mag, m_step, m_pts, m_syms, m_idx, settle_left;
  int m_scnt, m_ecnt, m_ecnt4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; m_mag = 0; m_step = 0; m_pts = 0; m_syms = 0;
      m_idx = 0; settle_left = 0;
      m_scnt = 0; m_ecnt = 0; m_ecnt4 = 0;
    end else if (abort) begin
      ph = 0;
    end else begin
      case (ph)
        0: if (start) begin
          m_mag = cfg_mag_start; m_step = cfg_mag_step;
          m_pts = cfg_num_pts; m_syms = cfg_symbols;
          m_idx = 0; settle_left = ST;
          ph = (cfg_num_pts == 0) ? 4 : 1;
        end
        1: begin
          settle_left--;
          if (settle_left == 0) begin
            ph = 2; m_scnt = 0; m_ecnt = 0; m_ecnt4 = 0;
          end
        end
        2: if (m_syms == 0) ph = 3;
           else if (sym_valid) begin
             m_scnt++;
             m_ecnt  = (m_ecnt + sym_bit_err > EMAX) ? EMAX : m_ecnt + sym_bit_err;
             m_ecnt4 = (m_ecnt4 + sym_bit_err > EMAX4) ? EMAX4 : m_ecnt4 + sym_bit_err;
             if (m_scnt == m_syms) ph = 3;
           end
        3: if (res_ready) begin
          m_idx++;
          if (m_idx == m_pts) ph = 4;
          else begin
            m_mag = (m_mag + m_step > MAGMAX) ? MAGMAX : m_mag + m_step;
            settle_left = ST; ph = 1;
          end
        end
        default: ph = 0;
      endcase
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, ph != 0);
      chk("awgn_en", awgn_en, ph == 1 || ph == 2);
      chk("noise_mag", noise_magnitude, ph == 0 ? 0 : m_mag);
      chk("res_valid", res_valid, ph == 3);
      chk("res_mag", res_mag, ph == 3 ? m_mag : 0);
      chk("res_symbols", res_symbols, ph == 3 ? m_scnt : 0);
      chk("res_errors", res_errors, ph == 3 ? m_ecnt : 0);
      chk("done", done, ph == 4);
      chk("sat_res_valid", s_res_valid, ph == 3);
      chk("sat_res_errors", s_res_errors, ph == 3 ? m_ecnt4 : 0);
      if (done) dn_cnt++;
    end
  end

  // Record every accepted result.
  always @(posedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      q_mag.push_back(int'(res_mag));
      q_sym.push_back(int'(res_symbols));
      q_err.push_back(int'(res_errors));
    end
    if (rst_n && s_res_valid && res_ready)
      q_err4.push_back(int'(s_res_errors));
  end

  task automatic clr_q();
    q_mag.delete(); q_sym.delete(); q_err.delete(); q_err4.delete();
  endtask

  task automatic kick(input int ms, input int stp, input int pts,
                      input int syms, input int err, input logic rdy);
    @(negedge clk);
    cfg_mag_start = MW'(ms); cfg_mag_step = MW'(stp);
    cfg_num_pts = 8'(pts); cfg_symbols = SW'(syms);
    sym_valid = 1'b1; sym_bit_err = 3'(err); res_ready = rdy;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_mag_start = 8'd99; cfg_mag_step = 8'd1;
    cfg_num_pts = 8'd9; cfg_symbols = SW'(2);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  int d0, k;
  logic seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_mag_start = '0; cfg_mag_step = '0; cfg_num_pts = '0;
    cfg_symbols = '0; sym_valid = 1'b0; sym_bit_err = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_noise", noise_magnitude, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal sweep, with a stray start mid-sweep.
    clr_q(); d0 = dn_cnt;
    kick(8, 8, 3, 10, 1, 1'b1);
    chk("c1_busy", busy, 1);
    chk("c1_awgn_en", awgn_en, 1);
    chk("c1_noise", noise_magnitude, 8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(300);
    chk("nom_npts", q_mag.size(), 3);
    if (q_mag.size() == 3) begin
      chk("nom_mag0", q_mag[0], 8);
      chk("nom_mag1", q_mag[1], 16);
      chk("nom_mag2", q_mag[2], 24);
      chk("nom_sym2", q_sym[2], 10);
      chk("nom_err2", q_err[2], 10);
    end
    chk("nom_done", dn_cnt - d0, 1);

    // Magnitude saturation.
    clr_q();
    kick(250, 8, 3, 4, 2, 1'b1);
    wait_idle(300);
    chk("sat_npts", q_mag.size(), 3);
    if (q_mag.size() == 3) begin
      chk("sat_mag0", q_mag[0], 250);
      chk("sat_mag1", q_mag[1], 255);
      chk("sat_mag2", q_mag[2], 255);
      chk("sat_err0", q_err[0], 8);
    end

    // Backpressure on the first of two points.
    clr_q();
    kick(40, 5, 2, 3, 2, 1'b0);
    k = 0;
    while (!res_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("bp_reach_report", res_valid, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_awgn_off", awgn_en, 0);
      chk("bp_mag", res_mag, 40);
      chk("bp_syms", res_symbols, 3);
      chk("bp_errs", res_errors, 6);
    end
    res_ready = 1'b1;
    wait_idle(200);
    chk("bp_npts", q_mag.size(), 2);
    if (q_mag.size() == 2) chk("bp_mag1", q_mag[1], 45);

    // Abort in MEASURE after 5 symbols.
    clr_q(); d0 = dn_cnt;
    kick(8, 8, 3, 10, 1, 1'b1);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_res_valid", res_valid, 0);
    chk("ab_noise", noise_magnitude, 0);
    repeat (10) @(negedge clk);
    chk("ab_no_done", dn_cnt - d0, 0);
    chk("ab_no_result", q_mag.size(), 0);

    // Abort and start together in IDLE.
    @(negedge clk);
    cfg_num_pts = 8'd2; cfg_symbols = SW'(3);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abst_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("abst_busy_later", busy, 0);

    // Zero points: done with no result.
    clr_q(); d0 = dn_cnt;
    @(negedge clk);
    cfg_num_pts = 8'd0; cfg_mag_start = 8'd30;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = done;
    @(negedge clk);
    seen = seen | done;
    chk("p0_done_by_2", seen, 1);
    repeat (3) @(negedge clk);
    chk("p0_done_once", dn_cnt - d0, 1);
    chk("p0_no_result", q_mag.size(), 0);

    // Zero symbols per point.
    clr_q();
    kick(12, 4, 1, 0, 3, 1'b1);
    wait_idle(50);
    chk("s0_npts", q_mag.size(), 1);
    if (q_mag.size() == 1) begin
      chk("s0_sym", q_sym[0], 0);
      chk("s0_err", q_err[0], 0);
    end

    // Error saturation in the 4-bit instance.
    clr_q();
    kick(20, 4, 1, 10, 4, 1'b1);
    wait_idle(100);
    chk("e4_npts", q_err4.size(), 1);
    if (q_err4.size() == 1) chk("e4_sat", q_err4[0], 15);
    if (q_err.size() == 1) chk("e24_err", q_err[0], 40);

    // Asynchronous reset mid-sweep.
    d0 = dn_cnt;
    kick(8, 8, 2, 5, 1, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_awgn", awgn_en, 0);
    chk("ar_noise", noise_magnitude, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("ar_no_done", dn_cnt - d0, 0);
    chk("ar_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
